// File: rtl/bomb_spawner.sv
// bomb_spawner: three-slot falling-bomb manager fed by the LFSR random bytes.
// Spawns, advances and collides bombs once per enabled frame tick; all outputs registered.
module bomb_spawner #(
  parameter int SCREEN_H        = 480,
  parameter int BOMB_SIZE       = 16,
  parameter int FALL_STEP       = 4,
  parameter int SPAWN_FRAMES    = 30,
  parameter int X_OFFSET        = 64,
  parameter int PLAYER_Y        = 448,
  parameter int PLAYER_W        = 32,
  parameter int COOLDOWN_FRAMES = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       enable,
  input  logic [7:0] rand_num0,
  input  logic [7:0] rand_num1,
  input  logic [7:0] rand_num2,
  input  logic [9:0] player_x,
  output logic [2:0] bomb_valid,
  output logic [9:0] bomb_x0,
  output logic [9:0] bomb_x1,
  output logic [9:0] bomb_x2,
  output logic [9:0] bomb_y0,
  output logic [9:0] bomb_y1,
  output logic [9:0] bomb_y2,
  output logic       hit,
  output logic [7:0] dodge_cnt
);

  localparam int SW = (SPAWN_FRAMES > 1) ? $clog2(SPAWN_FRAMES) : 1;
  localparam int CW = (COOLDOWN_FRAMES > 1) ? $clog2(COOLDOWN_FRAMES) : 1;
  localparam logic [SW-1:0] SPAWN_LAST = SW'(SPAWN_FRAMES - 1);
  localparam logic [CW-1:0] COOL_LAST  = CW'(COOLDOWN_FRAMES - 1);
  localparam logic [10:0]   STEP_W     = 11'(FALL_STEP);
  localparam logic [10:0]   SIZE_W     = 11'(BOMB_SIZE);
  localparam logic [10:0]   SCREEN_W   = 11'(SCREEN_H);
  localparam logic [10:0]   PY_W       = 11'(PLAYER_Y);
  localparam logic [10:0]   PW_W       = 11'(PLAYER_W);
  localparam logic [9:0]    XOFF_W     = 10'(X_OFFSET);

  typedef enum logic [0:0] {
    ST_RUN      = 1'b0,
    ST_COOLDOWN = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [2:0]      valid_q, valid_d;
  logic [2:0][9:0] x_q, x_d;
  logic [2:0][9:0] y_q, y_d;
  logic            hit_q, hit_d;
  logic [7:0]      dodge_q, dodge_d;
  logic [SW-1:0]   spawn_cnt_q, spawn_cnt_d;
  logic [CW-1:0]   cool_cnt_q, cool_cnt_d;

  logic             active_s;
  logic [2:0][7:0]  rand_s;
  logic [2:0][10:0] y_next_s;
  logic [2:0]       collide_s;
  logic [2:0]       exit_s;
  logic [1:0]       exit_num_s;
  logic [8:0]       dodge_sum_s;
  logic             any_hit_s;

  function automatic logic [9:0] spawn_x(input logic [7:0] r);
    return {1'b0, r, 1'b0} + XOFF_W;
  endfunction

  assign active_s = frame_tick & enable;
  assign rand_s   = {rand_num2, rand_num1, rand_num0};

  // Per-slot fall, collision and exit evaluation, 11-bit wide so nothing wraps.
  always_comb begin
    y_next_s  = {33{1'b0}};
    collide_s = 3'b000;
    exit_s    = 3'b000;
    for (int i = 0; i < 3; i++) begin
      y_next_s[i]  = {1'b0, y_q[i]} + STEP_W;
      collide_s[i] = valid_q[i]
                   & ({1'b0, x_q[i]} < ({1'b0, player_x} + PW_W))
                   & (({1'b0, x_q[i]} + SIZE_W) > {1'b0, player_x})
                   & ((y_next_s[i] + SIZE_W) > PY_W);
      exit_s[i]    = valid_q[i] & ~collide_s[i] & (y_next_s[i] >= SCREEN_W);
    end
    exit_num_s  = {1'b0, exit_s[0]} + {1'b0, exit_s[1]} + {1'b0, exit_s[2]};
    dodge_sum_s = {1'b0, dodge_q} + {7'd0, exit_num_s};
    any_hit_s   = |collide_s;
  end

  // Next-state: slot updates, spawn, FSM and counters; everything holds off-tick.
  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    x_d         = x_q;
    y_d         = y_q;
    hit_d       = 1'b0;
    dodge_d     = dodge_q;
    spawn_cnt_d = spawn_cnt_q;
    cool_cnt_d  = cool_cnt_q;
    if (active_s) begin
      for (int i = 0; i < 3; i++) begin
        if (collide_s[i] || exit_s[i]) begin
          valid_d[i] = 1'b0;
        end else if (valid_q[i]) begin
          y_d[i] = y_next_s[i][9:0];
        end else begin
          y_d[i] = y_q[i];
        end
      end
      hit_d   = any_hit_s;
      dodge_d = dodge_sum_s[8] ? 8'hFF : dodge_sum_s[7:0];
      case (state_q)
        ST_RUN: begin
          if (spawn_cnt_q == SPAWN_LAST) begin
            spawn_cnt_d = {SW{1'b0}};
            // Only slots that were already free before this tick are eligible.
            if (!valid_q[0]) begin
              valid_d[0] = 1'b1;
              x_d[0]     = spawn_x(rand_s[0]);
              y_d[0]     = 10'd0;
            end else if (!valid_q[1]) begin
              valid_d[1] = 1'b1;
              x_d[1]     = spawn_x(rand_s[1]);
              y_d[1]     = 10'd0;
            end else if (!valid_q[2]) begin
              valid_d[2] = 1'b1;
              x_d[2]     = spawn_x(rand_s[2]);
              y_d[2]     = 10'd0;
            end else begin
              valid_d = valid_d;
            end
          end else begin
            spawn_cnt_d = spawn_cnt_q + SW'(1'b1);
          end
          if (any_hit_s) begin
            state_d     = ST_COOLDOWN;
            cool_cnt_d  = {CW{1'b0}};
            spawn_cnt_d = {SW{1'b0}};
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_COOLDOWN: begin
          if (cool_cnt_q == COOL_LAST) begin
            state_d    = ST_RUN;
            cool_cnt_d = {CW{1'b0}};
          end else begin
            cool_cnt_d = cool_cnt_q + CW'(1'b1);
          end
        end
        default: begin
          state_d = ST_RUN;
        end
      endcase
    end else begin
      hit_d = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_RUN;
      valid_q     <= 3'b000;
      x_q         <= 30'd0;
      y_q         <= 30'd0;
      hit_q       <= 1'b0;
      dodge_q     <= 8'd0;
      spawn_cnt_q <= {SW{1'b0}};
      cool_cnt_q  <= {CW{1'b0}};
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      x_q         <= x_d;
      y_q         <= y_d;
      hit_q       <= hit_d;
      dodge_q     <= dodge_d;
      spawn_cnt_q <= spawn_cnt_d;
      cool_cnt_q  <= cool_cnt_d;
    end
  end

  assign bomb_valid = valid_q;
  assign bomb_x0    = x_q[0];
  assign bomb_x1    = x_q[1];
  assign bomb_x2    = x_q[2];
  assign bomb_y0    = y_q[0];
  assign bomb_y1    = y_q[1];
  assign bomb_y2    = y_q[2];
  assign hit        = hit_q;
  assign dodge_cnt  = dodge_q;

endmodule

// File: tb/tb_bomb_spawner.sv
// Bench for bomb_spawner: a default instance and a SPAWN_FRAMES=2 instance,
// each checked every cycle against a rule-level model, plus directed literal checks.
module tb_bomb_spawner;

  logic       clk        = 1'b0;
  logic       rst        = 1'b1;
  logic       frame_tick = 1'b0;
  logic       enable     = 1'b1;
  logic [7:0] rnd0       = 8'h40;
  logic [7:0] rnd1       = 8'h40;
  logic [7:0] rnd2       = 8'h40;
  logic [9:0] px         = 10'd600;

  logic [2:0] d_valid, f_valid;
  logic [9:0] d_x0, d_x1, d_x2, d_y0, d_y1, d_y2;
  logic [9:0] f_x0, f_x1, f_x2, f_y0, f_y1, f_y2;
  logic       d_hit, f_hit;
  logic [7:0] d_dodge, f_dodge;
  logic [71:0] d_vec, f_vec;

  always #5 clk = ~clk;

  bomb_spawner dut_d (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .enable(enable),
    .rand_num0(rnd0), .rand_num1(rnd1), .rand_num2(rnd2), .player_x(px),
    .bomb_valid(d_valid), .bomb_x0(d_x0), .bomb_x1(d_x1), .bomb_x2(d_x2),
    .bomb_y0(d_y0), .bomb_y1(d_y1), .bomb_y2(d_y2), .hit(d_hit), .dodge_cnt(d_dodge)
  );

  bomb_spawner #(.SPAWN_FRAMES(2)) dut_f (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .enable(enable),
    .rand_num0(rnd0), .rand_num1(rnd1), .rand_num2(rnd2), .player_x(px),
    .bomb_valid(f_valid), .bomb_x0(f_x0), .bomb_x1(f_x1), .bomb_x2(f_x2),
    .bomb_y0(f_y0), .bomb_y1(f_y1), .bomb_y2(f_y2), .hit(f_hit), .dodge_cnt(f_dodge)
  );

  assign d_vec = {d_valid, d_x2, d_x1, d_x0, d_y2, d_y1, d_y0, d_hit, d_dodge};
  assign f_vec = {f_valid, f_x2, f_x1, f_x0, f_y2, f_y1, f_y0, f_hit, f_dodge};

  int n_total    = 0;
  int n_pass     = 0;
  int hit_seen_d = 0;

  // Model state: index 0 = default instance, 1 = SPAWN_FRAMES=2 instance.
  int m_valid[2][3];
  int m_x[2][3];
  int m_y[2][3];
  int m_hit[2];
  int m_dodge[2];
  int m_scnt[2];
  int m_cd[2];
  int m_cool[2];

  function automatic int rnd_of(input int i);
    case (i)
      0:       return int'(rnd0);
      1:       return int'(rnd1);
      default: return int'(rnd2);
    endcase
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 3; i++) begin
        m_valid[d][i] = 0;
        m_x[d][i]     = 0;
        m_y[d][i]     = 0;
      end
      m_hit[d] = 0; m_dodge[d] = 0; m_scnt[d] = 0; m_cd[d] = 0; m_cool[d] = 0;
    end
  endtask

  task automatic model_step(input int d);
    int fb[3];
    int anyhit;
    int nexit;
    int yn;
    int sf;
    int done;
    int p;
    sf = (d == 0) ? 30 : 2;
    p  = int'(px);
    anyhit = 0;
    nexit  = 0;
    if (frame_tick && enable) begin
      for (int i = 0; i < 3; i++) fb[i] = (m_valid[d][i] == 0) ? 1 : 0;
      for (int i = 0; i < 3; i++) begin
        if (m_valid[d][i] != 0) begin
          yn = m_y[d][i] + 4;
          if (m_x[d][i] < p + 32 && m_x[d][i] + 16 > p && yn + 16 > 448) begin
            m_valid[d][i] = 0;
            anyhit = 1;
          end else if (yn >= 480) begin
            m_valid[d][i] = 0;
            nexit++;
          end else begin
            m_y[d][i] = yn;
          end
        end
      end
      m_dodge[d] = (m_dodge[d] + nexit > 255) ? 255 : m_dodge[d] + nexit;
      if (m_cool[d] == 0) begin
        if (m_scnt[d] == sf - 1) begin
          m_scnt[d] = 0;
          done = 0;
          for (int i = 0; i < 3; i++) begin
            if (done == 0 && fb[i] != 0) begin
              m_valid[d][i] = 1;
              m_x[d][i]     = rnd_of(i) * 2 + 64;
              m_y[d][i]     = 0;
              done = 1;
            end
          end
        end else begin
          m_scnt[d]++;
        end
        if (anyhit != 0) begin
          m_cool[d] = 1;
          m_cd[d]   = 0;
          m_scnt[d] = 0;
        end
      end else if (m_cd[d] == 59) begin
        m_cool[d] = 0;
        m_cd[d]   = 0;
      end else begin
        m_cd[d]++;
      end
    end
    m_hit[d] = anyhit;
  endtask

  function automatic logic [71:0] model_vec(input int d);
    logic [2:0] v;
    for (int i = 0; i < 3; i++) v[i] = (m_valid[d][i] != 0);
    return {v, 10'(m_x[d][2]), 10'(m_x[d][1]), 10'(m_x[d][0]),
            10'(m_y[d][2]), 10'(m_y[d][1]), 10'(m_y[d][0]),
            (m_hit[d] != 0), 8'(m_dodge[d])};
  endfunction

  task automatic check(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
  endtask

  task automatic cmp_vec(input string nm, input logic [71:0] act, input logic [71:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s t=%0t actual=%h expected=%h", nm, $time, act, exp);
  endtask

  // Model advances on the same edges the DUT samples.
  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else begin
        model_step(0);
        model_step(1);
      end
    end
  end

  // Per-cycle compare, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      cmp_vec("cycle_dut_d", d_vec, model_vec(0));
      cmp_vec("cycle_dut_f", f_vec, model_vec(1));
      if (d_hit) hit_seen_d = 1;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_ticks(input int n);
    repeat (n) begin
      @(negedge clk); frame_tick = 1'b1;
      @(negedge clk); frame_tick = 1'b0;
    end
  endtask

  task automatic do_fast(input int n);
    @(negedge clk); frame_tick = 1'b1;
    repeat (n) @(negedge clk);
    frame_tick = 1'b0;
  endtask

  task automatic apply_reset(input bit chk_zero);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    if (chk_zero) begin
      check("async_rst_valid", int'(d_valid), 0);
      check("async_rst_x1", int'(d_x1), 0);
      check("async_rst_y1", int'(d_y1), 0);
      check("async_rst_dodge", int'(d_dodge), 0);
      check("async_rst_hit", int'(d_hit), 0);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("reset_valid", int'(d_valid), 0);
    check("reset_x0", int'(d_x0), 0);
    check("reset_dodge", int'(d_dodge), 0);
    check("reset_hit", int'(d_hit), 0);

    // Spawn, fall, freeze, exit with a coincident dropped spawn.
    do_ticks(29);  check("p1_no_spawn_yet", int'(d_valid), 0);
    do_ticks(1);   check("p1_spawn_valid", int'(d_valid), 1);
    check("p1_spawn_x0", int'(d_x0), 192);
    check("p1_spawn_y0", int'(d_y0), 0);
    do_ticks(10);  check("p1_fall_y0", int'(d_y0), 40);
    enable = 1'b0;
    do_ticks(10);  check("p1_freeze_y0", int'(d_y0), 40);
    check("p1_freeze_valid", int'(d_valid), 1);
    enable = 1'b1;
    do_ticks(1);   check("p1_resume_y0", int'(d_y0), 44);
    do_ticks(108); check("p1_t149_valid", int'(d_valid), 7);
    check("p1_t149_y0", int'(d_y0), 476);
    do_ticks(1);   check("p1_exit_valid", int'(d_valid), 6);
    check("p1_exit_dodge", int'(d_dodge), 1);
    do_ticks(30);  check("p1_reuse_valid", int'(d_valid), 5);
    check("p1_reuse_y0", int'(d_y0), 0);
    check("p1_reuse_dodge", int'(d_dodge), 2);
    check("p1_no_hit", hit_seen_d, 0);

    // Collision and cooldown.
    apply_reset(1'b0);
    px = 10'd180; rnd0 = 8'h40; rnd1 = 8'hF0; rnd2 = 8'hF0;
    do_ticks(30);  check("p2_spawn_valid", int'(d_valid), 1);
    do_ticks(108); check("p2_pre_hit_y0", int'(d_y0), 432);
    check("p2_pre_hit_valid", int'(d_valid), 7);
    do_ticks(1);   check("p2_hit", int'(d_hit), 1);
    check("p2_hit_valid", int'(d_valid), 6);
    check("p2_hit_dodge", int'(d_dodge), 0);
    @(negedge clk); check("p2_hit_one_cycle", int'(d_hit), 0);
    do_ticks(60);  check("p2_cool_valid", int'(d_valid), 4);
    check("p2_cool_dodge", int'(d_dodge), 1);
    do_ticks(29);  check("p2_run_no_spawn", int'(d_valid), 0);
    do_ticks(1);   check("p2_respawn_valid", int'(d_valid), 1);
    check("p2_respawn_x0", int'(d_x0), 192);

    // Second hit, then async reset mid-cooldown with bombs live.
    do_ticks(109); check("p6_hit", int'(d_hit), 1);
    check("p6_hit_valid", int'(d_valid), 6);
    do_ticks(5);
    apply_reset(1'b1);
    do_ticks(29);  check("p6_post_rst_no_spawn", int'(d_valid), 0);
    do_ticks(1);   check("p6_post_rst_spawn", int'(d_valid), 1);
    check("p6_post_rst_x0", int'(d_x0), 192);

    // Slot fill priority on the SPAWN_FRAMES=2 instance.
    apply_reset(1'b0);
    px = 10'd600; rnd0 = 8'h00; rnd1 = 8'h10; rnd2 = 8'h20;
    do_ticks(2);   check("p3_fill0_valid", int'(f_valid), 1);
    check("p3_fill0_x0", int'(f_x0), 64);
    do_ticks(2);   check("p3_fill1_valid", int'(f_valid), 3);
    check("p3_fill1_x1", int'(f_x1), 96);
    do_ticks(2);   check("p3_fill2_valid", int'(f_valid), 7);
    check("p3_fill2_x2", int'(f_x2), 128);
    do_ticks(2);   check("p3_drop_valid", int'(f_valid), 7);
    check("p3_drop_y0", int'(f_y0), 24);
    do_ticks(114); check("p3_exit_drop_valid", int'(f_valid), 6);
    check("p3_exit_drop_dodge", int'(f_dodge), 1);
    do_ticks(2);   check("p3_refill_valid", int'(f_valid), 5);
    check("p3_refill_x0", int'(f_x0), 64);
    check("p3_refill_y0", int'(f_y0), 0);
    check("p3_refill_dodge", int'(f_dodge), 2);

    // Two slots colliding on one tick.
    apply_reset(1'b0);
    do_ticks(112);
    px = 10'd70;
    do_ticks(1);   check("p4_double_hit", int'(f_hit), 1);
    check("p4_double_valid", int'(f_valid), 4);
    check("p4_double_dodge", int'(f_dodge), 0);
    @(negedge clk); check("p4_hit_one_cycle", int'(f_hit), 0);

    // Dodge counter saturation.
    apply_reset(1'b0);
    px = 10'd600; rnd0 = 8'h40; rnd1 = 8'h40; rnd2 = 8'h40;
    hit_seen_d = 0;
    do_fast(12779); check("p5_dodge_253", int'(d_dodge), 253);
    do_fast(1);     check("p5_dodge_254", int'(d_dodge), 254);
    do_fast(30);    check("p5_dodge_255", int'(d_dodge), 255);
    do_fast(90);    check("p5_dodge_sat", int'(d_dodge), 255);
    check("p5_no_hit", hit_seen_d, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
